scan_sequencer: RTL
===================

Name: scan_sequencer

Overview:
Upstream driver for the 3-to-8 decoder. It steps a 3-bit channel select through the enabled channels of an 8-bit mask and holds each channel for a programmable dwell time. It supports continuous and single-sweep modes, in either direction. Used for display/keypad column scanning; its sel output connects directly to the decoder select input A.

Parameters:
DWELL_W, 16, width of dwell-count input and internal dwell counter
N_CH, 8, channel count; fixed at 8 (SEL_W = 3); other values unsupported

Ports:
clk  input  1  single system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin scanning; ignored while busy
stop  input  1  single-cycle request to abort scanning
mode  input  1  0 = continuous (wrap forever), 1 = single sweep
dir  input  1  0 = ascending channel order, 1 = descending
en_mask  input  8  bit i = 1 means channel i is visited; others skipped
dwell  input  DWELL_W  cycles each channel is held; 0 treated as 1
sel  output  3  current channel index, to decoder A
sel_valid  output  1  sel is an active scan channel
step_pulse  output  1  one-cycle pulse in the first cycle a new sel is presented
sweep_done  output  1  one-cycle pulse when a single sweep completes
busy  output  1  high in RUN state

Behaviour:
- Reset (synchronous, rst=1 at an edge): state=IDLE, sel=0, sel_valid=0, step_pulse=0, sweep_done=0, busy=0, dwell counter=0. Reset mid-scan aborts immediately, with no sweep_done.
- All outputs are registered; no combinational input-to-output paths.
- States: IDLE, RUN.
- IDLE:
  - sel holds its last value; sel_valid=0; busy=0.
  - start=1 and en_mask!=0 at edge t: the following take effect after edge t:
    - sel = lowest set bit of en_mask (dir=0) or highest set bit (dir=1)
    - sel_valid=1, busy=1, step_pulse=1
    - counter = max(dwell,1)-1
    - state=RUN
  - start with en_mask==0: ignored; stays IDLE.
- RUN:
  - The counter decrements each cycle. Each channel is visible for exactly max(dwell,1) cycles.
  - dwell is sampled only when a channel is loaded. Changes mid-dwell affect the next channel only.
  - On the cycle the counter==0 (advance):
    - Next channel is the next set bit of the current en_mask after sel in direction dir, searching with wrap-around.
    - wrap flag = search passed 7->0 (ascending) or 0->7 (descending).
    - Only one enabled channel: next = same channel with wrap=1. In continuous mode it reloads and pulses step_pulse again.
    - Continuous mode, or single mode without wrap: load next channel, step_pulse=1, reload counter.
    - Single mode with wrap: state=IDLE, sel_valid=0, busy=0, sweep_done=1 for one cycle; sel keeps the last channel.
    - en_mask==0 at advance: state=IDLE, sel_valid=0, busy=0, no sweep_done.
  - mode and dir are sampled at each advance.
  - stop=1: state=IDLE after that edge, sel_valid=0, busy=0, no sweep_done.
  - start while in RUN: ignored.
- Priority at an edge: rst > stop > advance > start.
- Simultaneous start and stop in IDLE: stays IDLE.
- step_pulse and sweep_done are never high in the same cycle.

Decomposition:
- Package scan_pkg:
  - constants N_CH=8, SEL_W=3
  - state enum {IDLE, RUN}
  - mode encodings MODE_CONT=0, MODE_SINGLE=1
  - direction encodings DIR_UP=0, DIR_DOWN=1
- Sub-module scan_next_ch (purely combinational):
  - inputs: cur[2:0], mask[7:0], dir
  - outputs: nxt[2:0], wrap, none (mask==0)
  - implemented as rotate-then-priority-encode
  - also used with cur = 7 (ascending) or 0 (descending) and the wrap output ignored, to find the first channel on start

Test Plan:
- Reset then idle: rst held 2 cycles -> sel=0, sel_valid=0, busy=0, step_pulse=0, sweep_done=0; start=0 keeps everything static for 20 cycles.
- Single sweep, en_mask=8'hFF, dwell=1, dir=0: start at t -> sel=0..7 on cycles t+1..t+8 with step_pulse every cycle; sweep_done=1 and sel_valid=0 at t+9; sel stays 7.
- Masked descending continuous sweep: en_mask=8'b1010_0101, dwell=3, dir=1, mode=0 -> sel sequence 7,5,2,0,7,5..., each held exactly 3 cycles; step_pulse on each change; no sweep_done.
- dwell=0 and single-channel mask: en_mask=8'h10, dwell=0, continuous -> sel=4 constant, sel_valid=1, step_pulse high every cycle; switching to mode=1 -> sweep_done at the next advance.
- Abort and priority: stop mid-dwell on channel 3 -> sel_valid=0, busy=0 next cycle, sel=3 held, no sweep_done; start+stop together in IDLE -> stays IDLE; start with en_mask=0 -> ignored.
- Reset mid-operation and mask cleared: rst during RUN -> all outputs at reset values next cycle; separately, en_mask cleared to 0 mid-run -> IDLE at the next advance with no sweep_done.

Source files
------------

// File: rtl/scan_pkg.sv
// scan_pkg: shared constants and encodings for the channel scan sequencer.
//   N_CH / SEL_W  : channel count and select width (fixed 8 / 3)
//   state_e       : sequencer FSM states
//   MODE_* / DIR_*: encodings of the mode and dir inputs
package scan_pkg;
  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic MODE_CONT   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;
  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;
endpackage

// File: rtl/scan_next_ch.sv
// scan_next_ch: combinational search for the next enabled channel after cur.
//   cur  : current channel
//   mask : enabled-channel mask
//   dir  : DIR_UP searches cur+1, cur+2, ...; DIR_DOWN searches cur-1, cur-2, ...
//   nxt  : first enabled channel found (wraps around; may equal cur)
//   wrap : search crossed 7->0 (up) or 0->7 (down)
//   none : mask is empty; nxt/wrap are meaningless
module scan_next_ch
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0] cur,
  input  logic [N_CH-1:0]  mask,
  input  logic             dir,
  output logic [SEL_W-1:0] nxt,
  output logic             wrap,
  output logic             none
);

  logic [N_CH-1:0]  rot;
  logic [SEL_W-1:0] off;

  always_comb begin
    // Rotate the mask so bit i is the channel i+1 steps away from cur.
    rot = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (dir == DIR_DOWN) rot[i] = mask[cur - SEL_W'(i + 1)];
      else                 rot[i] = mask[cur + SEL_W'(i + 1)];
    end
    // Lowest set bit of the rotated mask = distance-1 to the next channel.
    off = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    none = (mask == '0);
    // Modular arithmetic: a wrap shows up as the result not moving past cur.
    if (dir == DIR_DOWN) begin
      nxt  = cur - off - SEL_W'(1);
      wrap = (nxt >= cur);
    end else begin
      nxt  = cur + off + SEL_W'(1);
      wrap = (nxt <= cur);
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 3-bit decoder select through the enabled channels
// of en_mask, holding each for max(dwell,1) cycles, continuous or single sweep.
//   clk, rst   : clock, synchronous active-high reset
//   start/stop : single-cycle scan request / abort
//   mode, dir  : continuous/single sweep, ascending/descending (sampled at advance)
//   en_mask    : enabled channels; dwell: hold time per channel (0 acts as 1)
//   sel, sel_valid, step_pulse, sweep_done, busy : registered scan outputs
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic               dir,
  input  logic [N_CH-1:0]    en_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               step_pulse,
  output logic               sweep_done,
  output logic               busy
);

  state_e             state, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n, dwell_ld;
  logic [SEL_W-1:0]   sel_n, adv_nxt, first_ch, first_cur;
  logic               valid_n, step_n, done_n;
  logic               adv_wrap, adv_none, first_none, first_wrap_unused;

  // Counter holds "cycles left after this one"; dwell of 0 behaves as 1.
  assign dwell_ld = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  // Searching from the far end finds the lowest (up) / highest (down) channel.
  assign first_cur = (dir == DIR_DOWN) ? '0 : '1;

  scan_next_ch u_adv (
    .cur(sel), .mask(en_mask), .dir(dir),
    .nxt(adv_nxt), .wrap(adv_wrap), .none(adv_none)
  );

  scan_next_ch u_first (
    .cur(first_cur), .mask(en_mask), .dir(dir),
    .nxt(first_ch), .wrap(first_wrap_unused), .none(first_none)
  );

  always_comb begin
    state_n = state;
    sel_n   = sel;
    valid_n = sel_valid;
    step_n  = 1'b0;
    done_n  = 1'b0;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        valid_n = 1'b0;
        if (start && !stop && !first_none) begin
          state_n = RUN;
          sel_n   = first_ch;
          valid_n = 1'b1;
          step_n  = 1'b1;
          cnt_n   = dwell_ld;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          valid_n = 1'b0;
        end else if (cnt == '0) begin
          if (adv_none) begin
            state_n = IDLE;
            valid_n = 1'b0;
          end else if (mode == MODE_SINGLE && adv_wrap) begin
            state_n = IDLE;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end else begin
            sel_n  = adv_nxt;
            step_n = 1'b1;
            cnt_n  = dwell_ld;
          end
        end else begin
          cnt_n = cnt - DWELL_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= '0;
      sel_valid  <= 1'b0;
      step_pulse <= 1'b0;
      sweep_done <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      sel_valid  <= valid_n;
      step_pulse <= step_n;
      sweep_done <= done_n;
      cnt        <= cnt_n;
    end
  end

  assign busy = (state == RUN);

endmodule
